// File: rtl/bist_lfsr_misr.sv
// Built-in self-test controller for a combinational CUT.
// A Fibonacci LFSR drives patterns, and a MISR compacts the responses.
// After NPAT patterns the final signature is compared against GOLDEN.
// The signature can then be shifted out serially on SO under SE control.
module bist_lfsr_misr #(
   parameter int               WIDTH  = 8,
   parameter logic [WIDTH-1:0] TAPS   = 8'hB8,
   parameter logic [WIDTH-1:0] SEED   = 8'h01,
   parameter int               NPAT   = 255,
   parameter logic [WIDTH-1:0] GOLDEN = '0
) (
   input  logic             CLK,
   input  logic             RSTn,
   input  logic             START,
   input  logic             SE,
   input  logic [WIDTH-1:0] RESP,
   output logic [WIDTH-1:0] PAT,
   output logic             BUSY,
   output logic             DONE,
   output logic             PASS,
   output logic [WIDTH-1:0] SIG,
   output logic             SO
);

   localparam int CW = $clog2(NPAT + 1);

   // An all-zero seed would lock the LFSR, so it is replaced by 1.
   localparam logic [WIDTH-1:0] SEED_EFF =
      (SEED == '0) ? {{(WIDTH-1){1'b0}}, 1'b1} : SEED;
   localparam logic [CW-1:0] LAST = CW'(NPAT - 1);

   typedef enum logic [1:0] {
      S_IDLE,
      S_RUN,
      S_DONE
   } state_e;

   state_e           state_q, state_d;
   logic [WIDTH-1:0] lfsr_q, lfsr_d;
   logic [WIDTH-1:0] misr_q, misr_d;
   logic [CW-1:0]    cnt_q, cnt_d;
   logic             pass_q, pass_d;

   logic [WIDTH-1:0] misr_next;
   logic             load;

   // Shared LFSR/MISR step: left shift with the tap parity entering bit 0.
   function automatic logic [WIDTH-1:0] step(input logic [WIDTH-1:0] x);
      return {x[WIDTH-2:0], ^(x & TAPS)};
   endfunction

   assign misr_next = step(misr_q) ^ RESP;

   // A run request is honoured only from IDLE or DONE.
   // In DONE it has priority over scan shifting.
   assign load = START && (state_q == S_IDLE || state_q == S_DONE);

   // Next-state logic for the FSM and all datapath registers.
   always_comb begin
      // NOTE: every signal gets a hold default first, so no path through the case can infer a latch.
      state_d = state_q;
      lfsr_d  = lfsr_q;
      misr_d  = misr_q;
      cnt_d   = cnt_q;
      pass_d  = pass_q;

      if (load) begin
         state_d = S_RUN;
         lfsr_d  = SEED_EFF;
         misr_d  = '0;
         cnt_d   = '0;
         pass_d  = 1'b0;
      end else begin
         case (state_q)
            S_RUN: begin
               lfsr_d = step(lfsr_q);
               misr_d = misr_next;
               cnt_d  = cnt_q + CW'(1);
               if (cnt_q == LAST) begin
                  state_d = S_DONE;
                  pass_d  = (misr_next == GOLDEN);
               end
            end
            S_DONE: begin
               if (SE) misr_d = {misr_q[WIDTH-2:0], 1'b0};
            end
            S_IDLE:  ;
            default: state_d = S_IDLE;
         endcase
      end
   end

   // State and datapath registers, cleared asynchronously.
   always_ff @(posedge CLK or negedge RSTn) begin
      if (!RSTn) begin
         state_q <= S_IDLE;
         lfsr_q  <= '0;
         misr_q  <= '0;
         cnt_q   <= '0;
         pass_q  <= 1'b0;
      end else begin
         // NOTE: non-blocking assignments make every register sample pre-edge values, whatever the statement order.
         state_q <= state_d;
         lfsr_q  <= lfsr_d;
         misr_q  <= misr_d;
         cnt_q   <= cnt_d;
         pass_q  <= pass_d;
      end
   end

   assign PAT  = lfsr_q;
   assign SIG  = misr_q;
   assign BUSY = (state_q == S_RUN);
   assign DONE = (state_q == S_DONE);
   assign PASS = pass_q;
   assign SO   = (state_q == S_DONE) ? misr_q[WIDTH-1] : 1'b0;

endmodule

// File: tb/tb_bist_lfsr_misr.sv
// Testbench for bist_lfsr_misr.
// Four instances cover different parameter sets:
//   dut_a - full pattern sequence
//   dut_b - loopback compaction that passes
//   dut_c - loopback compaction that fails
//   dut_d - zero seed
// The PAT stream of dut_a is scoreboarded. Stimulus pushes the expected
// patterns into a queue, and a monitor pops one for every BUSY cycle.
module tb_bist_lfsr_misr;

   localparam int W = 4;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   logic         start_a = 0, start_bc = 0, start_d = 0;
   logic         se_a = 0, se_b = 0, se_c = 0, se_d = 0;
   logic [W-1:0] resp_a = '0, resp_d = '0;
   logic [W-1:0] resp_b, resp_c;

   logic [W-1:0] pat_a, pat_b, pat_c, pat_d;
   logic [W-1:0] sig_a, sig_b, sig_c, sig_d;
   logic busy_a, busy_b, busy_c, busy_d;
   logic done_a, done_b, done_c, done_d;
   logic pass_a, pass_b, pass_c, pass_d;
   logic so_a, so_b, so_c, so_d;

   // The loopback CUT is a plain wire from pattern to response.
   assign resp_b = pat_b;
   assign resp_c = pat_c;

   bist_lfsr_misr #(.WIDTH(W), .TAPS(4'h9), .SEED(4'h1), .NPAT(15), .GOLDEN(4'h0)) dut_a (
      .CLK(clk), .RSTn(rst_n), .START(start_a), .SE(se_a), .RESP(resp_a),
      .PAT(pat_a), .BUSY(busy_a), .DONE(done_a), .PASS(pass_a), .SIG(sig_a), .SO(so_a));

   bist_lfsr_misr #(.WIDTH(W), .TAPS(4'h9), .SEED(4'h1), .NPAT(3), .GOLDEN(4'h7)) dut_b (
      .CLK(clk), .RSTn(rst_n), .START(start_bc), .SE(se_b), .RESP(resp_b),
      .PAT(pat_b), .BUSY(busy_b), .DONE(done_b), .PASS(pass_b), .SIG(sig_b), .SO(so_b));

   bist_lfsr_misr #(.WIDTH(W), .TAPS(4'h9), .SEED(4'h1), .NPAT(3), .GOLDEN(4'h6)) dut_c (
      .CLK(clk), .RSTn(rst_n), .START(start_bc), .SE(se_c), .RESP(resp_c),
      .PAT(pat_c), .BUSY(busy_c), .DONE(done_c), .PASS(pass_c), .SIG(sig_c), .SO(so_c));

   bist_lfsr_misr #(.WIDTH(W), .TAPS(4'h9), .SEED(4'h0), .NPAT(15), .GOLDEN(4'h0)) dut_d (
      .CLK(clk), .RSTn(rst_n), .START(start_d), .SE(se_d), .RESP(resp_d),
      .PAT(pat_d), .BUSY(busy_d), .DONE(done_d), .PASS(pass_d), .SIG(sig_d), .SO(so_d));

   // Hand-derived maximal sequence for x^4 with taps at bits 3 and 0, seed 1.
   logic [W-1:0] seq [15] = '{4'h1, 4'h3, 4'h7, 4'hF, 4'hE, 4'hD, 4'hA, 4'h5,
                              4'hB, 4'h6, 4'hC, 4'h9, 4'h2, 4'h4, 4'h8};

   logic [W-1:0] exp_q [$];
   int n_cmp = 0;
   int n_err = 0;
   int busy_cnt = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   // Monitor: every BUSY cycle of dut_a must present the next expected pattern.
   always @(negedge clk) begin
      if (rst_n && busy_a) begin
         busy_cnt++;
         if (exp_q.size() == 0) begin
            n_cmp++;
            n_err++;
            $display("FAIL pat_a: BUSY with no pattern expected, got %0h (t=%0t)", pat_a, $time);
         end else begin
            check("pat_a", 32'(pat_a), 32'(exp_q.pop_front()));
         end
      end
   end

   task automatic push_seq();
      for (int i = 0; i < 15; i++) exp_q.push_back(seq[i]);
   endtask

   // One-cycle START pulse. The call returns at edge k + 1 time unit,
   // that is, inside cycle k+1.
   task automatic pulse(input int which);
      case (which)
         0: start_a = 1'b1;
         1: start_bc = 1'b1;
         default: start_d = 1'b1;
      endcase
      @(posedge clk); #1;
      start_a = 1'b0;
      start_bc = 1'b0;
      start_d = 1'b0;
   endtask

   function automatic logic done_of(input int which);
      case (which)
         0: return done_a;
         1: return done_b;
         default: return done_d;
      endcase
   endfunction

   task automatic wait_done(input int which, input string name);
      int n = 0;
      while (!done_of(which) && n < 100) begin
         @(posedge clk); #1;
         n++;
      end
      if (!done_of(which)) begin
         n_cmp++;
         n_err++;
         $display("FAIL %s: DONE not seen within 100 cycles", name);
      end
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   logic [W-1:0] scan_sig [4] = '{4'hE, 4'hC, 4'h8, 4'h0};
   logic         scan_so  [4] = '{1'b1, 1'b1, 1'b0, 1'b0};

   initial begin
      // Scan bits after each shift of 0111: 1, 1, 1, then 0 once empty.
      scan_so[2] = 1'b1;

      // Reset state.
      #12;
      check("rst_pat", 32'(pat_a), 0);
      check("rst_sig", 32'(sig_a), 0);
      check("rst_busy", 32'(busy_a), 0);
      check("rst_done", 32'(done_a), 0);
      check("rst_pass", 32'(pass_a), 0);
      check("rst_so", 32'(so_a), 0);
      rst_n = 1'b1;
      @(posedge clk); #1;

      // Full pattern sequence.
      busy_cnt = 0;
      push_seq();
      pulse(0);
      check("busy_after_start", 32'(busy_a), 1);
      wait_done(0, "seq_done");
      check("seq_busy_cycles", 32'(busy_cnt), 15);
      check("seq_busy_low", 32'(busy_a), 0);
      check("seq_pass", 32'(pass_a), 1);
      check("seq_sig", 32'(sig_a), 0);

      // Restart from DONE, with START pulsed again mid-run (ignored).
      busy_cnt = 0;
      push_seq();
      pulse(0);
      repeat (3) begin
         @(posedge clk); #1;
      end
      pulse(0);
      wait_done(0, "ignore_done");
      check("ignore_busy_cycles", 32'(busy_cnt), 15);
      check("ignore_queue_empty", 32'(exp_q.size()), 0);

      // Reset at pattern 5: outputs clear without a clock edge.
      push_seq();
      pulse(0);
      repeat (5) begin
         @(posedge clk); #1;
      end
      check("pat5_before_reset", 32'(pat_a), 32'h0D);
      rst_n = 1'b0;
      #1;
      check("midrst_pat", 32'(pat_a), 0);
      check("midrst_busy", 32'(busy_a), 0);
      check("midrst_done", 32'(done_a), 0);
      check("midrst_sig", 32'(sig_a), 0);
      check("midrst_pass", 32'(pass_a), 0);
      check("midrst_so", 32'(so_a), 0);
      exp_q.delete();
      #2 rst_n = 1'b1;
      @(posedge clk); #1;
      busy_cnt = 0;
      push_seq();
      pulse(0);
      check("rerun_first_pat", 32'(pat_a), 1);
      wait_done(0, "rerun_done");
      check("rerun_busy_cycles", 32'(busy_cnt), 15);

      // Loopback compaction with a passing and a failing golden value.
      pulse(1);
      wait_done(1, "loop_done");
      check("loop_sig_b", 32'(sig_b), 32'h7);
      check("loop_pass_b", 32'(pass_b), 1);
      check("loop_sig_c", 32'(sig_c), 32'h7);
      check("loop_pass_c", 32'(pass_c), 0);
      check("loop_done_c", 32'(done_c), 1);
      check("scan_so_first", 32'(so_b), 0);
      @(posedge clk); #1;
      check("done_hold_sig", 32'(sig_b), 32'h7);

      // Scan-out of 0111, MSB first.
      se_b = 1'b1;
      for (int i = 0; i < 4; i++) begin
         @(posedge clk); #1;
         check($sformatf("scan_so_%0d", i), 32'(so_b), 32'(scan_so[i]));
         check($sformatf("scan_sig_%0d", i), 32'(sig_b), 32'(scan_sig[i]));
      end
      se_b = 1'b0;
      check("scan_pass_kept", 32'(pass_b), 1);
      check("scan_done_kept", 32'(done_b), 1);

      // START together with SE in DONE restarts the run.
      pulse(1);
      wait_done(1, "rerun_b_done");
      check("rerun_b_sig", 32'(sig_b), 32'h7);
      start_bc = 1'b1;
      se_b = 1'b1;
      @(posedge clk); #1;
      start_bc = 1'b0;
      se_b = 1'b0;
      check("restart_sig", 32'(sig_b), 0);
      check("restart_pass", 32'(pass_b), 0);
      check("restart_busy", 32'(busy_b), 1);
      check("restart_done", 32'(done_b), 0);
      check("restart_pat", 32'(pat_b), 1);
      wait_done(1, "restart_done_wait");
      check("restart_final_sig", 32'(sig_b), 32'h7);
      check("restart_final_pass", 32'(pass_b), 1);

      // Zero seed with a constant-zero response.
      pulse(2);
      check("zseed_first_pat", 32'(pat_d), 1);
      wait_done(2, "zseed_done");
      check("zseed_sig", 32'(sig_d), 0);
      check("zseed_pass", 32'(pass_d), 1);

      check("final_queue_empty", 32'(exp_q.size()), 0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
